fofb_orbit_error_stream: RTL and testbench

- Sits directly downstream of the FOFB link readout stream (index/X/Y/S/valid packets, one per BPM per FA cycle).
- Subtracts per-BPM X/Y setpoints held in internal RAM and gates packets with low sum (S) signal.
- Emits an orbit-error stream for the correction DSP.
- Keeps per-FA-cycle integrity statistics (packet count, duplicates, stray packets) for the microBlaze.

---
 rtl/fofb_orbit_error_stream.sv | 163 ++++++++++++++++
 tb/tb_fofb_orbit_error_stream.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fofb_orbit_error_stream.sv
// FOFB orbit-error stream: subtracts per-BPM setpoints from readout packets, gates on sum
// signal, and keeps per-FA-cycle integrity statistics.
module fofb_orbit_error_stream #(
  parameter int unsigned FOFB_INDEX_WIDTH    = 9,
  parameter logic [31:0] SUM_THRESHOLD_RESET = 32'd1000
) (
  input  logic                        sysClk,
  input  logic                        sysReset_n,
  input  logic                        FAstrobe,
  input  logic [FOFB_INDEX_WIDTH-1:0] readoutIndex,
  input  logic [31:0]                 readoutX,
  input  logic [31:0]                 readoutY,
  input  logic [31:0]                 readoutS,
  input  logic                        readoutValid,
  input  logic                        spWriteStrobe,
  input  logic [FOFB_INDEX_WIDTH-1:0] spWriteAddr,
  input  logic                        spWriteSelY,
  input  logic [31:0]                 spWriteData,
  input  logic                        thrWriteStrobe,
  input  logic [31:0]                 thrWriteData,
  output logic [FOFB_INDEX_WIDTH-1:0] errIndex,
  output logic [31:0]                 errX,
  output logic [31:0]                 errY,
  output logic                        errSumOk,
  output logic                        errValid,
  output logic                        cycleDone,
  output logic [FOFB_INDEX_WIDTH:0]   cyclePacketCount,
  output logic [7:0]                  cycleDupCount,
  output logic [15:0]                 strayCount
);

  localparam int unsigned Depth = 2 ** FOFB_INDEX_WIDTH;
  localparam logic [FOFB_INDEX_WIDTH:0] PktOne = 1;

  typedef enum logic {StIdle, StOpen} state_e;
  state_e state_q, state_d;

  logic [31:0] sp_x_mem [Depth];
  logic [31:0] sp_y_mem [Depth];

  logic [31:0]                 thr_q;
  logic [Depth-1:0]            seen_q, seen_d;
  logic [FOFB_INDEX_WIDTH:0]   pkt_q, pkt_d;
  logic [7:0]                  dup_q, dup_d;
  logic [15:0]                 stray_q, stray_d;
  logic                        accept, snapshot;

  logic                        s1_valid_q, s1_sum_ok_q;
  logic [FOFB_INDEX_WIDTH-1:0] s1_idx_q;
  logic [31:0]                 s1_x_q, s1_y_q, s1_sp_x_q, s1_sp_y_q;

  logic [FOFB_INDEX_WIDTH-1:0] err_idx_q;
  logic [31:0]                 err_x_q, err_y_q, err_x_d, err_y_d;
  logic                        err_sum_ok_q, err_valid_q, cycle_done_q;
  logic [FOFB_INDEX_WIDTH:0]   cyc_pkt_q;
  logic [7:0]                  cyc_dup_q;

  function automatic logic [31:0] sat32(input logic [32:0] d);
    if (d[32] != d[31]) return d[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return d[31:0];
  endfunction

  // Setpoint RAM, read-first: a same-cycle write is not visible to the read.
  always_ff @(posedge sysClk) begin
    if (spWriteStrobe && !spWriteSelY) sp_x_mem[spWriteAddr] <= spWriteData;
    if (spWriteStrobe && spWriteSelY)  sp_y_mem[spWriteAddr] <= spWriteData;
    s1_sp_x_q <= sp_x_mem[readoutIndex];
    s1_sp_y_q <= sp_y_mem[readoutIndex];
  end

  always_comb begin
    state_d = state_q;
    if (FAstrobe) state_d = StOpen;
  end

  assign accept   = readoutValid && ((state_q == StOpen) || FAstrobe);
  assign snapshot = FAstrobe && (state_q == StOpen);

  // A strobe clears the running state first, so a coincident packet lands in the new cycle.
  always_comb begin
    seen_d  = FAstrobe ? '0 : seen_q;
    pkt_d   = FAstrobe ? '0 : pkt_q;
    dup_d   = FAstrobe ? '0 : dup_q;
    stray_d = stray_q;
    if (accept) begin
      if (seen_d[readoutIndex]) begin
        if (dup_d != 8'hFF) dup_d = dup_d + 8'd1;
      end else begin
        seen_d[readoutIndex] = 1'b1;
        pkt_d                = pkt_d + PktOne;
      end
    end
    if (readoutValid && (state_q == StIdle) && !FAstrobe && (stray_q != 16'hFFFF)) begin
      stray_d = stray_q + 16'd1;
    end
  end

  always_comb begin
    err_x_d = '0;
    err_y_d = '0;
    if (s1_sum_ok_q) begin
      err_x_d = sat32({s1_x_q[31], s1_x_q} - {s1_sp_x_q[31], s1_sp_x_q});
      err_y_d = sat32({s1_y_q[31], s1_y_q} - {s1_sp_y_q[31], s1_sp_y_q});
    end
  end

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state_q      <= StIdle;
      thr_q        <= SUM_THRESHOLD_RESET;
      seen_q       <= '0;
      pkt_q        <= '0;
      dup_q        <= '0;
      stray_q      <= '0;
      s1_valid_q   <= 1'b0;
      s1_sum_ok_q  <= 1'b0;
      s1_idx_q     <= '0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      err_idx_q    <= '0;
      err_x_q      <= '0;
      err_y_q      <= '0;
      err_sum_ok_q <= 1'b0;
      err_valid_q  <= 1'b0;
      cycle_done_q <= 1'b0;
      cyc_pkt_q    <= '0;
      cyc_dup_q    <= '0;
    end else begin
      state_q      <= state_d;
      if (thrWriteStrobe) thr_q <= thrWriteData;
      seen_q       <= seen_d;
      pkt_q        <= pkt_d;
      dup_q        <= dup_d;
      stray_q      <= stray_d;
      s1_valid_q   <= accept;
      s1_sum_ok_q  <= readoutS >= thr_q;
      s1_idx_q     <= readoutIndex;
      s1_x_q       <= readoutX;
      s1_y_q       <= readoutY;
      err_idx_q    <= s1_idx_q;
      err_x_q      <= err_x_d;
      err_y_q      <= err_y_d;
      err_sum_ok_q <= s1_sum_ok_q;
      err_valid_q  <= s1_valid_q;
      cycle_done_q <= snapshot;
      if (snapshot) begin
        cyc_pkt_q <= pkt_q;
        cyc_dup_q <= dup_q;
      end
    end
  end

  assign errIndex         = err_idx_q;
  assign errX             = err_x_q;
  assign errY             = err_y_q;
  assign errSumOk         = err_sum_ok_q;
  assign errValid         = err_valid_q;
  assign cycleDone        = cycle_done_q;
  assign cyclePacketCount = cyc_pkt_q;
  assign cycleDupCount    = cyc_dup_q;
  assign strayCount       = stray_q;

endmodule

// File: tb/tb_fofb_orbit_error_stream.sv
// Directed bench for fofb_orbit_error_stream: latency, saturation, sum gating, statistics.
module tb_fofb_orbit_error_stream;

  localparam int unsigned IW = 9;

  logic          sysClk = 1'b0;
  logic          sysReset_n;
  logic          FAstrobe;
  logic [IW-1:0] readoutIndex;
  logic [31:0]   readoutX, readoutY, readoutS;
  logic          readoutValid;
  logic          spWriteStrobe;
  logic [IW-1:0] spWriteAddr;
  logic          spWriteSelY;
  logic [31:0]   spWriteData;
  logic          thrWriteStrobe;
  logic [31:0]   thrWriteData;
  logic [IW-1:0] errIndex;
  logic [31:0]   errX, errY;
  logic          errSumOk, errValid, cycleDone;
  logic [IW:0]   cyclePacketCount;
  logic [7:0]    cycleDupCount;
  logic [15:0]   strayCount;

  int checks = 0;
  int errors = 0;

  fofb_orbit_error_stream dut (
    .sysClk           (sysClk),
    .sysReset_n       (sysReset_n),
    .FAstrobe         (FAstrobe),
    .readoutIndex     (readoutIndex),
    .readoutX         (readoutX),
    .readoutY         (readoutY),
    .readoutS         (readoutS),
    .readoutValid     (readoutValid),
    .spWriteStrobe    (spWriteStrobe),
    .spWriteAddr      (spWriteAddr),
    .spWriteSelY      (spWriteSelY),
    .spWriteData      (spWriteData),
    .thrWriteStrobe   (thrWriteStrobe),
    .thrWriteData     (thrWriteData),
    .errIndex         (errIndex),
    .errX             (errX),
    .errY             (errY),
    .errSumOk         (errSumOk),
    .errValid         (errValid),
    .cycleDone        (cycleDone),
    .cyclePacketCount (cyclePacketCount),
    .cycleDupCount    (cycleDupCount),
    .strayCount       (strayCount)
  );

  always #5 sysClk = ~sysClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge sysClk);
    #1;
  endtask

  // Drives one packet for one clock; returns one step after its sampling edge.
  task automatic send(input logic [IW-1:0] idx, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] s);
    readoutIndex = idx; readoutX = x; readoutY = y; readoutS = s; readoutValid = 1'b1;
    step();
    readoutValid = 1'b0;
  endtask

  task automatic write_sp(input logic [IW-1:0] addr, input logic sel_y, input logic [31:0] d);
    spWriteStrobe = 1'b1; spWriteAddr = addr; spWriteSelY = sel_y; spWriteData = d;
    step();
    spWriteStrobe = 1'b0;
  endtask

  task automatic strobe();
    FAstrobe = 1'b1;
    step();
    FAstrobe = 1'b0;
  endtask

  task automatic test_reset();
    sysReset_n = 1'b0;
    step(); step();
    checks++; if (errValid !== 1'b0) begin errors++; $display("FAIL reset_errValid got %0h want 0", errValid); end
    checks++; if (errX !== 32'd0) begin errors++; $display("FAIL reset_errX got %0h want 0", errX); end
    checks++; if (cycleDone !== 1'b0) begin errors++; $display("FAIL reset_cycleDone got %0h want 0", cycleDone); end
    checks++; if (cyclePacketCount !== '0) begin errors++; $display("FAIL reset_pktcnt got %0h want 0", cyclePacketCount); end
    checks++; if (strayCount !== 16'd0) begin errors++; $display("FAIL reset_stray got %0h want 0", strayCount); end
    sysReset_n = 1'b1;
    step();
  endtask

  task automatic test_stray();
    int vcount = 0;
    for (int i = 0; i < 3; i++) begin
      send(IW'(i + 10), 32'd1, 32'd1, 32'd5000);
      if (errValid) vcount++;
    end
    step(); if (errValid) vcount++;
    step(); if (errValid) vcount++;
    checks++; if (vcount != 0) begin errors++; $display("FAIL stray_no_valid got %0d want 0", vcount); end
    checks++; if (strayCount !== 16'd3) begin errors++; $display("FAIL stray_count got %0d want 3", strayCount); end
  endtask

  task automatic test_basic();
    write_sp(5, 1'b0, 32'd100);
    write_sp(5, 1'b1, 32'hFFFF_FFCE);
    strobe();
    send(5, 32'd1100, 32'd0, 32'd5000);
    checks++; if (errValid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0h want 0", errValid); end
    step();
    checks++; if (errValid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0h want 1", errValid); end
    checks++; if (errIndex !== IW'(5)) begin errors++; $display("FAIL basic_index got %0d want 5", errIndex); end
    checks++; if (errX !== 32'd1000) begin errors++; $display("FAIL basic_errX got %0h want 3e8", errX); end
    checks++; if (errY !== 32'd50) begin errors++; $display("FAIL basic_errY got %0h want 32", errY); end
    checks++; if (errSumOk !== 1'b1) begin errors++; $display("FAIL basic_sumok got %0h want 1", errSumOk); end
    step();
    checks++; if (errValid !== 1'b0) begin errors++; $display("FAIL basic_single_pulse got %0h want 0", errValid); end
  endtask

  task automatic test_saturation();
    write_sp(1, 1'b0, 32'h8000_0000);
    write_sp(1, 1'b1, 32'd0);
    write_sp(2, 1'b0, 32'd1);
    write_sp(2, 1'b1, 32'd0);
    send(1, 32'h7FFF_FFFF, 32'd0, 32'd5000);
    step();
    checks++; if (errX !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_pos got %0h want 7fffffff", errX); end
    send(2, 32'h8000_0000, 32'd0, 32'd5000);
    step();
    checks++; if (errX !== 32'h8000_0000) begin errors++; $display("FAIL sat_neg got %0h want 80000000", errX); end
  endtask

  task automatic test_threshold();
    send(5, 32'd1100, 32'd0, 32'd999);
    step();
    checks++; if (errValid !== 1'b1) begin errors++; $display("FAIL thr_low_valid got %0h want 1", errValid); end
    checks++; if (errSumOk !== 1'b0) begin errors++; $display("FAIL thr_low_sumok got %0h want 0", errSumOk); end
    checks++; if (errX !== 32'd0 || errY !== 32'd0) begin errors++; $display("FAIL thr_low_zero got %0h/%0h want 0/0", errX, errY); end
    send(5, 32'd1100, 32'd0, 32'd1000);
    step();
    checks++; if (errSumOk !== 1'b1) begin errors++; $display("FAIL thr_eq_sumok got %0h want 1", errSumOk); end
    checks++; if (errX !== 32'd1000) begin errors++; $display("FAIL thr_eq_errX got %0h want 3e8", errX); end
    thrWriteStrobe = 1'b1; thrWriteData = 32'd2000;
    step();
    thrWriteStrobe = 1'b0;
    send(5, 32'd1100, 32'd0, 32'd1500);
    step();
    checks++; if (errSumOk !== 1'b0) begin errors++; $display("FAIL thr_new_sumok got %0h want 0", errSumOk); end
    thrWriteStrobe = 1'b1; thrWriteData = 32'd1000;
    step();
    thrWriteStrobe = 1'b0;
  endtask

  task automatic test_stats();
    logic [IW-1:0] idx_tab [4] = '{IW'(0), IW'(1), IW'(1), IW'(2)};
    int vcount = 0;
    strobe();
    step(); step();
    for (int i = 0; i < 4; i++) begin
      send(idx_tab[i], 32'd0, 32'd0, 32'd5000);
      if (errValid) vcount++;
    end
    strobe();
    if (errValid) vcount++;
    checks++; if (vcount != 4) begin errors++; $display("FAIL stats_emitted got %0d want 4", vcount); end
    checks++; if (cycleDone !== 1'b1) begin errors++; $display("FAIL stats_done got %0h want 1", cycleDone); end
    checks++; if (cyclePacketCount !== 10'd3) begin errors++; $display("FAIL stats_pkt got %0d want 3", cyclePacketCount); end
    checks++; if (cycleDupCount !== 8'd1) begin errors++; $display("FAIL stats_dup got %0d want 1", cycleDupCount); end
    step();
    checks++; if (cycleDone !== 1'b0) begin errors++; $display("FAIL stats_done_pulse got %0h want 0", cycleDone); end
  endtask

  task automatic test_back_to_back();
    send(5, 32'd1100, 32'd0, 32'd5000);
    send(2, 32'd5, 32'd0, 32'd5000);
    checks++; if (errValid !== 1'b1 || errIndex !== IW'(5) || errX !== 32'd1000) begin
      errors++; $display("FAIL b2b_first got v%0h i%0d x%0h want v1 i5 x3e8", errValid, errIndex, errX);
    end
    step();
    checks++; if (errValid !== 1'b1 || errIndex !== IW'(2) || errX !== 32'd4) begin
      errors++; $display("FAIL b2b_second got v%0h i%0d x%0h want v1 i2 x4", errValid, errIndex, errX);
    end
    step();
    checks++; if (errValid !== 1'b0) begin errors++; $display("FAIL b2b_end got %0h want 0", errValid); end
  endtask

  task automatic test_coincident();
    strobe();
    step(); step();
    FAstrobe = 1'b1;
    send(7, 32'd0, 32'd0, 32'd5000);
    FAstrobe = 1'b0;
    checks++; if (cycleDone !== 1'b1 || cyclePacketCount !== 10'd0) begin
      errors++; $display("FAIL coinc_close got done%0h pkt%0d want done1 pkt0", cycleDone, cyclePacketCount);
    end
    step(); step();
    strobe();
    checks++; if (cycleDone !== 1'b1 || cyclePacketCount !== 10'd1 || cycleDupCount !== 8'd0) begin
      errors++; $display("FAIL coinc_next got done%0h pkt%0d dup%0d want done1 pkt1 dup0",
                         cycleDone, cyclePacketCount, cycleDupCount);
    end
  endtask

  task automatic test_collision();
    write_sp(3, 1'b0, 32'd10);
    write_sp(3, 1'b1, 32'd0);
    spWriteStrobe = 1'b1; spWriteAddr = 3; spWriteSelY = 1'b0; spWriteData = 32'd20;
    send(3, 32'd30, 32'd0, 32'd5000);
    spWriteStrobe = 1'b0;
    step();
    checks++; if (errX !== 32'd20) begin errors++; $display("FAIL collide_old got %0d want 20", errX); end
    send(3, 32'd30, 32'd0, 32'd5000);
    step();
    checks++; if (errX !== 32'd10) begin errors++; $display("FAIL collide_new got %0d want 10", errX); end
  endtask

  task automatic test_reset_midflight();
    send(5, 32'd1100, 32'd0, 32'd5000);
    sysReset_n = 1'b0;
    #1;
    checks++; if (errValid !== 1'b0) begin errors++; $display("FAIL midrst_during got %0h want 0", errValid); end
    step();
    checks++; if (errValid !== 1'b0) begin errors++; $display("FAIL midrst_hold got %0h want 0", errValid); end
    sysReset_n = 1'b1;
    step();
    checks++; if (errValid !== 1'b0) begin errors++; $display("FAIL midrst_after got %0h want 0", errValid); end
    send(4, 32'd0, 32'd0, 32'd5000);
    step();
    checks++; if (errValid !== 1'b0 || strayCount !== 16'd1) begin
      errors++; $display("FAIL midrst_idle got v%0h stray%0d want v0 stray1", errValid, strayCount);
    end
  endtask

  initial begin
    sysReset_n = 1'b0; FAstrobe = 1'b0; readoutValid = 1'b0; readoutIndex = '0;
    readoutX = '0; readoutY = '0; readoutS = '0; spWriteStrobe = 1'b0; spWriteAddr = '0;
    spWriteSelY = 1'b0; spWriteData = '0; thrWriteStrobe = 1'b0; thrWriteData = '0;
    test_reset();
    test_stray();
    test_basic();
    test_saturation();
    test_threshold();
    test_stats();
    test_back_to_back();
    test_coincident();
    test_collision();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
